dsram_responder: RTL and testbench

Serves the CPU's single-cycle data SRAM port (request in EX, `data_sram_rdata` consumed by MEM the next cycle) over an external variable-latency SRAM-like bus. It sits between the EX/MEM data port and the memory/AXI bridge. It stalls the pipeline via `stallreq` until the external access completes, then holds the load word stable for MEM to sample. It issues each request exactly once, even though EX keeps re-presenting the request while stalled.

---
 rtl/dsram_responder.sv | 111 +++++++++++
 tb/tb_dsram_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dsram_responder.sv
// Bridges the CPU's single-cycle data SRAM port onto a variable-latency SRAM-like bus.
// Stalls EX until the external access finishes, then holds the load word for MEM.
module dsram_responder #(
   parameter int unsigned KSEG_MAP = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        data_sram_en,
   input  logic [3:0]  data_sram_wen,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic [31:0] data_sram_rdata,
   output logic        stallreq,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_DONE
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic        w_accept;
   logic        w_done;
   logic [31:0] w_paddr;

   logic        r_mem_wr;
   logic [3:0]  r_mem_wstrb;
   logic [31:0] r_mem_addr;
   logic [31:0] r_mem_wdata;
   logic [31:0] r_rdata;

   // kseg0/kseg1 both alias the low 512 MB of physical memory
   always_comb begin
      w_paddr = data_sram_addr;
      if ((KSEG_MAP != 0) && (data_sram_addr[31:30] == 2'b10)) begin
         w_paddr = {3'b000, data_sram_addr[28:0]};
      end
   end

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_done   = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_accept = data_sram_en & ~flush;
            if (w_accept) w_next = S_ADDR;
         end
         S_ADDR: begin
            if (mem_addr_ok) begin
               w_done = mem_data_ok;
               w_next = mem_data_ok ? S_DONE : S_DATA;
            end
         end
         S_DATA: begin
            if (mem_data_ok) begin
               w_done = 1'b1;
               w_next = S_DONE;
            end
         end
         // DONE drops the stall for one cycle so EX advances without re-issuing
         S_DONE: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_mem_wr    <= 1'b0;
         r_mem_wstrb <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else if (w_accept) begin
         r_mem_wr    <= |data_sram_wen;
         r_mem_wstrb <= data_sram_wen;
         r_mem_addr  <= w_paddr;
         r_mem_wdata <= data_sram_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)                     r_rdata <= '0;
      else if (w_done && !r_mem_wr) r_rdata <= mem_rdata;
   end

   assign mem_req         = (r_state == S_ADDR);
   assign mem_wr          = r_mem_wr;
   assign mem_wstrb       = r_mem_wstrb;
   assign mem_addr        = r_mem_addr;
   assign mem_wdata       = r_mem_wdata;
   assign data_sram_rdata = r_rdata;
   assign stallreq        = ~rst & (w_accept | (r_state == S_ADDR) | (r_state == S_DATA));

endmodule

// File: tb/tb_dsram_responder.sv
// Bench for dsram_responder: table of bus transactions plus reset/flush corner sequences,
// with a request scoreboard checked against what appears on the external bus.
module tb_dsram_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        en;
   logic [3:0]  wen;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] mrdata;

   logic [31:0] rdata,    d1_rdata;
   logic        stall,    d1_stall;
   logic        req,      d1_req;
   logic        wr,       d1_wr;
   logic [3:0]  wstrb,    d1_wstrb;
   logic [31:0] maddr,    d1_maddr;
   logic [31:0] mwdata,   d1_mwdata;

   always #5 clk = ~clk;

   dsram_responder #(.KSEG_MAP(1)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .data_sram_en(en), .data_sram_wen(wen), .data_sram_addr(addr), .data_sram_wdata(wdata),
      .data_sram_rdata(rdata), .stallreq(stall),
      .mem_req(req), .mem_wr(wr), .mem_wstrb(wstrb), .mem_addr(maddr), .mem_wdata(mwdata),
      .mem_addr_ok(addr_ok), .mem_data_ok(data_ok), .mem_rdata(mrdata)
   );

   // unmapped twin sees identical stimulus; its addresses must pass through untouched
   dsram_responder #(.KSEG_MAP(0)) dut_raw (
      .clk(clk), .rst(rst), .flush(flush),
      .data_sram_en(en), .data_sram_wen(wen), .data_sram_addr(addr), .data_sram_wdata(wdata),
      .data_sram_rdata(d1_rdata), .stallreq(d1_stall),
      .mem_req(d1_req), .mem_wr(d1_wr), .mem_wstrb(d1_wstrb), .mem_addr(d1_maddr), .mem_wdata(d1_mwdata),
      .mem_addr_ok(addr_ok), .mem_data_ok(data_ok), .mem_rdata(mrdata)
   );

   typedef struct {
      logic [3:0]  wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [31:0] paddr;
      int          alat;
      int          dlat;
      int          idle;
      bit          hold;
      bit          fl0;
      bit          flmid;
   } vec_t;

   typedef struct {
      logic        wr;
      logic [3:0]  wstrb;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] raw;
   } req_t;

   req_t        sbq[$];
   vec_t        vecs[9];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_rdata = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic run_txn(input vec_t v);
      int   nreq;
      req_t e;
      for (int i = 0; i < v.idle; i++) begin
         @(negedge clk);
         en = 1'b0; flush = 1'b0; addr_ok = 1'b0; data_ok = 1'b1; mrdata = $urandom;
         #1;
         chk("idle_stall", {31'b0, stall}, 0);
         chk("idle_req", {31'b0, req}, 0);
         chk("idle_rdata_hold", rdata, exp_rdata);
      end
      @(negedge clk);
      en = 1'b1; wen = v.wen; addr = v.addr; wdata = v.wdata; flush = v.fl0;
      addr_ok = 1'b0; data_ok = 1'b0;
      #1;
      chk("accept_stall", {31'b0, stall}, v.fl0 ? 0 : 1);
      chk("accept_req", {31'b0, req}, 0);
      if (v.fl0) begin
         @(negedge clk);
         en = 1'b0; flush = 1'b0;
         #1;
         chk("flush_req", {31'b0, req}, 0);
         chk("flush_stall", {31'b0, stall}, 0);
         return;
      end
      sbq.push_back('{|v.wen, v.wen, v.paddr, v.wdata, v.addr});
      nreq = 0;
      for (int c = 1; c <= v.dlat; c++) begin
         @(negedge clk);
         en = v.hold; flush = v.flmid;
         addr_ok = (c >= v.alat);
         data_ok = (c == v.dlat);
         mrdata  = data_ok ? v.rdata : $urandom;
         #1;
         chk("bus_req", {31'b0, req}, (c <= v.alat) ? 1 : 0);
         chk("raw_req", {31'b0, d1_req}, (c <= v.alat) ? 1 : 0);
         chk("busy_stall", {31'b0, stall}, 1);
         chk("raw_stall", {31'b0, d1_stall}, 1);
         if (req) begin
            if (sbq.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL sb_empty: got mem_req with no request expected (t=%0t)", $time);
            end else begin
               e = sbq[0];
               chk("req_wr", {31'b0, wr}, {31'b0, e.wr});
               chk("req_wstrb", {28'b0, wstrb}, {28'b0, e.wstrb});
               chk("req_addr", maddr, e.addr);
               chk("req_wdata", mwdata, e.wdata);
               chk("raw_addr", d1_maddr, e.raw);
               chk("raw_wstrb", {28'b0, d1_wstrb}, {28'b0, e.wstrb});
               chk("raw_wr", {31'b0, d1_wr}, {31'b0, e.wr});
               chk("raw_wdata", d1_mwdata, e.wdata);
               if (addr_ok) begin
                  void'(sbq.pop_front());
                  nreq++;
               end
            end
         end
      end
      if (v.wen == 4'b0000) exp_rdata = v.rdata;
      @(negedge clk);
      addr_ok = 1'b0; data_ok = 1'b0; flush = 1'b0; en = v.hold; mrdata = $urandom;
      #1;
      chk("done_stall", {31'b0, stall}, 0);
      chk("done_req", {31'b0, req}, 0);
      chk("done_rdata", rdata, exp_rdata);
      chk("raw_rdata", d1_rdata, exp_rdata);
      chk("req_count", nreq, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before timeout");
      $fatal(1);
   end

   initial begin
      //            wen      addr          wdata         rdata         paddr       alat dlat idle hold fl0 flmid
      vecs[0] = '{4'b0000, 32'h8000_0010, 32'h0,        32'hDEAD_BEEF, 32'h0000_0010, 1, 3, 1, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{4'b0011, 32'hA000_1004, 32'h0000_1234, 32'h0,        32'h0000_1004, 2, 3, 2, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{4'b0000, 32'h0000_0040, 32'h0,        32'h0000_0001, 32'h0000_0040, 1, 1, 1, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{4'b0000, 32'h0000_0001, 32'h0,        32'h0000_00AA, 32'h0000_0001, 1, 1, 0, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{4'b0000, 32'h0000_0002, 32'h0,        32'h1234_5678, 32'h0000_0002, 3, 5, 0, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{4'b0000, 32'h8000_0300, 32'h0,        32'h0,        32'h0,         1, 1, 1, 1'b0, 1'b1, 1'b0};
      vecs[6] = '{4'b0000, 32'h8000_0020, 32'h0,        32'h5555_AAAA, 32'h0000_0020, 1, 4, 1, 1'b0, 1'b0, 1'b1};
      vecs[7] = '{4'b1111, 32'hBFC0_0008, 32'hCAFE_F00D, 32'h0,        32'h1FC0_0008, 1, 1, 1, 1'b1, 1'b0, 1'b0};
      vecs[8] = '{4'b0000, 32'h4000_0100, 32'h0,        32'h0BAD_F00D, 32'h4000_0100, 2, 2, 1, 1'b0, 1'b0, 1'b0};

      rst = 1'b1; flush = 1'b0; en = 1'b1; wen = '0; addr = 32'h8000_0000; wdata = '0;
      addr_ok = 1'b0; data_ok = 1'b0; mrdata = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_stall_forced", {31'b0, stall}, 0);
      @(negedge clk);
      rst = 1'b0; en = 1'b0;
      #1;
      chk("rst_req", {31'b0, req}, 0);
      chk("rst_wr", {31'b0, wr}, 0);
      chk("rst_wstrb", {28'b0, wstrb}, 0);
      chk("rst_addr", maddr, 0);
      chk("rst_wdata", mwdata, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_stall", {31'b0, stall}, 0);

      for (int i = 0; i < 9; i++) run_txn(vecs[i]);

      // reset while waiting for data: outstanding access is dropped
      @(negedge clk);
      en = 1'b1; wen = 4'b0000; addr = 32'h8000_0100; flush = 1'b0; addr_ok = 1'b0; data_ok = 1'b0;
      #1;
      chk("rstmid_accept_stall", {31'b0, stall}, 1);
      @(negedge clk);
      en = 1'b0; addr_ok = 1'b1;
      #1;
      chk("rstmid_req", {31'b0, req}, 1);
      @(negedge clk);
      addr_ok = 1'b0;
      #1;
      chk("rstmid_data_req", {31'b0, req}, 0);
      chk("rstmid_data_stall", {31'b0, stall}, 1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rstmid_stall_forced", {31'b0, stall}, 0);
      @(negedge clk);
      rst = 1'b0;
      exp_rdata = '0;
      #1;
      chk("rstmid_idle_req", {31'b0, req}, 0);
      chk("rstmid_idle_stall", {31'b0, stall}, 0);
      chk("rstmid_rdata", rdata, 0);
      @(negedge clk);
      data_ok = 1'b1; mrdata = 32'hFFFF_0000;
      #1;
      chk("late_data_stall", {31'b0, stall}, 0);
      @(negedge clk);
      data_ok = 1'b0;
      #1;
      chk("late_data_ignored", rdata, 0);

      run_txn('{4'b0000, 32'h8000_0200, 32'h0, 32'h7777_1111, 32'h0000_0200, 2, 3, 1, 1'b0, 1'b0, 1'b0});

      @(negedge clk);
      en = 1'b0;
      #1;
      chk("final_idle_stall", {31'b0, stall}, 0);
      chk("final_rdata_hold", rdata, exp_rdata);
      chk("sb_drained", sbq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
